dcache: RTL

Blocking, direct-mapped, write-back data cache that acts as the responder on the core's `dmem_*` interface, the interface the load/store unit drives as initiator. It accepts one load or store at a time, returns a one-cycle `dmem_resp`, and fills or evicts whole 32-byte lines over a line-granular backing-memory interface. It sits between the load/store unit and the memory arbiter.

---
 rtl/dcache_pkg.sv | 15 +
 rtl/dcache_line_array.sv | 65 ++++++
 rtl/dcache.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared types for the data cache: controller states and line geometry.
// Imported by dcache and dcache_line_array.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } dcache_state_t;

  localparam int DCACHE_LINE_BYTES = 32;
  localparam int DCACHE_LINE_BITS  = 256;

endpackage

// File: rtl/dcache_line_array.sv
// Flop-based line store: valid/dirty/tag/data per set, one comb read port.
// Ports: idx selects set; fill_* writes a whole line; merge_* writes bytes of a word.
module dcache_line_array
  import rv32i_types::*;
#(
  parameter int SETS  = 16,
  parameter int TAG_W = 23
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(SETS)-1:0]     idx,
  output logic                        rd_valid,
  output logic                        rd_dirty,
  output logic [TAG_W-1:0]            rd_tag,
  output logic [DCACHE_LINE_BITS-1:0] rd_line,
  input  logic                        fill_en,
  input  logic [TAG_W-1:0]            fill_tag,
  input  logic [DCACHE_LINE_BITS-1:0] fill_line,
  input  logic                        merge_en,
  input  logic [2:0]                  merge_word,
  input  logic [3:0]                  merge_mask,
  input  logic [31:0]                 merge_data,
  input  logic                        clean_en
);

  logic [SETS-1:0]             valid_q;
  logic [SETS-1:0]             dirty_q;
  logic [TAG_W-1:0]            tag_q  [SETS];
  logic [DCACHE_LINE_BITS-1:0] data_q [SETS];

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (merge_en) begin
      dirty_q[idx] <= 1'b1;
    end else if (clean_en) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // Tags and data carry no reset; valid gates their use.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (merge_en) begin
      for (int b = 0; b < 4; b++) begin
        if (merge_mask[b]) begin
          data_q[idx][{merge_word, b[1:0], 3'b000} +: 8] <=
            merge_data[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/dcache.sv
// Blocking direct-mapped write-back data cache between the LSU and memory.
// Ports: dmem_* request/response from the core; mem_* line fill/writeback.
module dcache
  import rv32i_types::*;
#(
  parameter int SETS = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [31:0]                 dmem_addr,
  input  logic [3:0]                  dmem_rmask,
  input  logic [3:0]                  dmem_wmask,
  input  logic [31:0]                 dmem_wdata,
  output logic [31:0]                 dmem_rdata,
  output logic                        dmem_resp,
  output logic [31:0]                 mem_addr,
  output logic                        mem_read,
  output logic                        mem_write,
  output logic [DCACHE_LINE_BITS-1:0] mem_wdata,
  input  logic [DCACHE_LINE_BITS-1:0] mem_rdata,
  input  logic                        mem_resp
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - 5 - IW;

  dcache_state_t state, state_n;

  logic [31:2] req_addr;
  logic [3:0]  req_rmask;
  logic [3:0]  req_wmask;
  logic [31:0] req_wdata;

  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic [2:0]    req_word;

  logic                        rd_valid;
  logic                        rd_dirty;
  logic [TW-1:0]               rd_tag;
  logic [DCACHE_LINE_BITS-1:0] rd_line;

  logic is_req, accept, hit;
  logic fill_en, merge_en, clean_en;

  logic unused_ok;
  assign unused_ok = &{1'b0, dmem_addr[1:0], req_rmask};

  assign req_idx  = req_addr[5+IW-1:5];
  assign req_tag  = req_addr[31:5+IW];
  assign req_word = req_addr[4:2];

  assign is_req = (|dmem_rmask) | (|dmem_wmask);
  assign hit    = rd_valid && (rd_tag == req_tag);

  dcache_line_array #(
    .SETS  (SETS),
    .TAG_W (TW)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx        (req_idx),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .fill_en    (fill_en),
    .fill_tag   (req_tag),
    .fill_line  (mem_rdata),
    .merge_en   (merge_en),
    .merge_word (req_word),
    .merge_mask (req_wmask),
    .merge_data (req_wdata),
    .clean_en   (clean_en)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr  <= '0;
      req_rmask <= '0;
      req_wmask <= '0;
      req_wdata <= '0;
    end else if (accept) begin
      req_addr  <= dmem_addr[31:2];
      req_rmask <= dmem_rmask;
      req_wmask <= dmem_wmask;
      req_wdata <= dmem_wdata;
    end
  end

  always_comb begin
    state_n    = state;
    accept     = 1'b0;
    dmem_resp  = 1'b0;
    dmem_rdata = '0;
    fill_en    = 1'b0;
    merge_en   = 1'b0;
    clean_en   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        if (is_req) begin
          accept  = 1'b1;
          state_n = COMPARE;
        end
      end
      COMPARE: begin
        if (hit) begin
          // Pre-merge word is returned even when a store is merged.
          dmem_resp  = 1'b1;
          dmem_rdata = rd_line[{req_word, 5'b00000} +: 32];
          merge_en   = |req_wmask;
          accept     = is_req;
          state_n    = is_req ? COMPARE : IDLE;
        end else begin
          state_n = rd_dirty ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_addr  = {rd_tag, req_idx, 5'b00000};
        mem_wdata = rd_line;
        if (mem_resp) begin
          clean_en = 1'b1;
          state_n  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        mem_read = 1'b1;
        mem_addr = {req_tag, req_idx, 5'b00000};
        if (mem_resp) begin
          fill_en = 1'b1;
          state_n = COMPARE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
